seven_seg_scan_controller: RTL and testbench

SEVEN_SEG_SCAN_CONTROLLER -- requirements
Module: seven_seg_scan_controller

---
 rtl/seven_seg_scan_controller.sv | 221 ++++++++++++++++++++++
 tb/tb_seven_seg_scan_controller.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan_controller.sv
// rtl/seven_seg_scan_controller.sv - binary-to-BCD converter driving a multiplexed seven-segment display
// Optional feature macro: LEADING_ZERO_BLANK_EN (blank leading zeros within each field)
module seven_seg_scan_controller #(
  parameter int NUM_FIELDS       = 2,
  parameter int DIGITS_PER_FIELD = 4,
  parameter int BIN_WIDTH        = 16,
  parameter int DIGIT_PERIOD     = 131072
) (
  input  logic                                     clock_100Mhz,
  input  logic                                     reset,
  input  logic [NUM_FIELDS*BIN_WIDTH-1:0]          value_in,
  input  logic                                     load,
  input  logic [NUM_FIELDS*DIGITS_PER_FIELD-1:0]   dp_in,
  output logic                                     busy,
  output logic [NUM_FIELDS-1:0]                    overflow,
  output logic [NUM_FIELDS*DIGITS_PER_FIELD-1:0]   anode_activate,
  output logic [7:0]                               LED_out
);

  localparam int NUM_DIGITS = NUM_FIELDS * DIGITS_PER_FIELD;
  localparam int BCD_W      = 4 * DIGITS_PER_FIELD;
  localparam int VAL_W      = NUM_FIELDS * BIN_WIDTH;
  localparam int FW         = (NUM_FIELDS > 1)   ? $clog2(NUM_FIELDS)   : 1;
  localparam int DW         = (NUM_DIGITS > 1)   ? $clog2(NUM_DIGITS)   : 1;
  localparam int BW         = (BIN_WIDTH > 1)    ? $clog2(BIN_WIDTH)    : 1;
  localparam int CW         = (DIGIT_PERIOD > 1) ? $clog2(DIGIT_PERIOD) : 1;
  localparam logic [63:0] MAX_VAL = 64'(10**DIGITS_PER_FIELD - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, STORE} state_t;

  state_t                state, state_n;
  logic [VAL_W-1:0]      cap_value;
  logic [VAL_W-1:0]      cap_next;
  logic [FW-1:0]         field_idx;
  logic [BW-1:0]         bit_cnt;
  logic [BIN_WIDTH-1:0]  shift_bin;
  logic [BCD_W-1:0]      shift_bcd;
  logic [BCD_W-1:0]      dd_adj;
  logic [3:0]            stage_digit   [NUM_DIGITS];
  logic [3:0]            stage_digit_n [NUM_DIGITS];
  logic [NUM_FIELDS-1:0] stage_ovf, stage_ovf_n;
  logic [3:0]            disp_digit    [NUM_DIGITS];
  logic [CW-1:0]         scan_cnt;
  logic [DW-1:0]         digit_idx;
  logic [NUM_DIGITS-1:0] lz_blank;
  logic                  last_field, last_bit, ovf_now;
  logic [3:0]            cur_bcd;
  logic                  cur_dash, cur_blank;
  logic [6:0]            seg;

  assign last_field = (field_idx == FW'(NUM_FIELDS - 1));
  assign last_bit   = (bit_cnt == BW'(BIN_WIDTH - 1));
  assign cap_next   = cap_value >> BIN_WIDTH;
  // The field being converted always sits in the low bits of cap_value.
  assign ovf_now    = 64'(cap_value[BIN_WIDTH-1:0]) > MAX_VAL;
  assign busy       = (state != IDLE);

  // Conversion state register.
  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Next-state logic: loads are only honoured in IDLE, so a load while busy is dropped.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (load) state_n = SHIFT;
      SHIFT:   if (last_bit) state_n = STORE;
      STORE:   state_n = last_field ? IDLE : SHIFT;
      default: state_n = IDLE;
    endcase
  end

  // Double-dabble add-3 correction on every BCD nibble before the shift.
  always_comb begin
    dd_adj = shift_bcd;
    for (int i = 0; i < DIGITS_PER_FIELD; i++) begin
      if (shift_bcd[4*i +: 4] >= 4'd5) dd_adj[4*i +: 4] = shift_bcd[4*i +: 4] + 4'd3;
    end
  end

  // Staging update: in STORE the finished field's digits (MS digit first) replace its slots.
  always_comb begin
    stage_digit_n = stage_digit;
    stage_ovf_n   = stage_ovf;
    if (state == STORE) begin
      for (int f = 0; f < NUM_FIELDS; f++) begin
        if (field_idx == FW'(f)) begin
          stage_ovf_n[f] = ovf_now;
          for (int j = 0; j < DIGITS_PER_FIELD; j++)
            stage_digit_n[f*DIGITS_PER_FIELD + j] = shift_bcd[4*(DIGITS_PER_FIELD-1-j) +: 4];
        end
      end
    end
  end

  // Conversion datapath: capture, per-field shifting, staging and the all-fields commit.
  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) begin
      cap_value <= '0;
      field_idx <= '0;
      bit_cnt   <= '0;
      shift_bin <= '0;
      shift_bcd <= '0;
      stage_ovf <= '0;
      overflow  <= '0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
        stage_digit[k] <= '0;
        disp_digit[k]  <= '0;
      end
    end else begin
      stage_digit <= stage_digit_n;
      stage_ovf   <= stage_ovf_n;
      case (state)
        IDLE: begin
          if (load) begin
            cap_value <= value_in;
            field_idx <= '0;
            bit_cnt   <= '0;
            shift_bin <= value_in[BIN_WIDTH-1:0];
            shift_bcd <= '0;
          end
        end
        SHIFT: begin
          // The bit pushed out of the top nibble is rotated into shift_bin's LSB; it can
          // never reach the MSB within one field's BIN_WIDTH steps, so it is harmless.
          shift_bcd <= {dd_adj[BCD_W-2:0], shift_bin[BIN_WIDTH-1]};
          shift_bin <= {shift_bin[BIN_WIDTH-2:0], dd_adj[BCD_W-1]};
          bit_cnt   <= bit_cnt + 1'b1;
        end
        STORE: begin
          bit_cnt   <= '0;
          shift_bcd <= '0;
          if (last_field) begin
            for (int k = 0; k < NUM_DIGITS; k++) disp_digit[k] <= stage_digit_n[k];
            overflow <= stage_ovf_n;
          end else begin
            field_idx <= field_idx + 1'b1;
            cap_value <= cap_next;
            shift_bin <= cap_next[BIN_WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  // Scan timer: each digit stays lit for DIGIT_PERIOD cycles, then the next one is selected.
  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) begin
      scan_cnt  <= '0;
      digit_idx <= '0;
    end else if (scan_cnt == CW'(DIGIT_PERIOD - 1)) begin
      scan_cnt  <= '0;
      digit_idx <= (digit_idx == DW'(NUM_DIGITS - 1)) ? '0 : digit_idx + 1'b1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  // Blank zeros left of a field's first nonzero digit; the field's LS digit is never blanked.
  always_comb begin
    logic run;
    run      = 1'b1;
    lz_blank = '0;
    for (int f = 0; f < NUM_FIELDS; f++) begin
      run = 1'b1;
      for (int j = 0; j < DIGITS_PER_FIELD - 1; j++) begin
        run = run & (disp_digit[f*DIGITS_PER_FIELD + j] == 4'd0);
        lz_blank[f*DIGITS_PER_FIELD + j] = run;
      end
    end
  end
`else
  assign lz_blank = '0;
`endif

  // Select the lit digit's value/flags and drive its anode low (digit 0 is leftmost).
  always_comb begin
    cur_bcd        = 4'd0;
    cur_dash       = 1'b0;
    cur_blank      = 1'b0;
    anode_activate = '1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (digit_idx == DW'(k)) begin
        cur_bcd   = disp_digit[k];
        cur_dash  = overflow[k / DIGITS_PER_FIELD];
        cur_blank = lz_blank[k];
        anode_activate[NUM_DIGITS-1-k] = 1'b0;
      end
    end
  end

  // Active-low segment decode a..g; an overflowed field shows a dash on every digit.
  always_comb begin
    seg = 7'b1111111;
    if (cur_dash) begin
      seg = 7'b1111110;
    end else if (!cur_blank) begin
      case (cur_bcd)
        4'd0:    seg = 7'b0000001;
        4'd1:    seg = 7'b1001111;
        4'd2:    seg = 7'b0010010;
        4'd3:    seg = 7'b0000110;
        4'd4:    seg = 7'b1001100;
        4'd5:    seg = 7'b0100100;
        4'd6:    seg = 7'b0100000;
        4'd7:    seg = 7'b0001111;
        4'd8:    seg = 7'b0000000;
        4'd9:    seg = 7'b0000100;
        default: seg = 7'b1111111;
      endcase
    end
  end

  // The decimal point follows dp_in live, not the committed value.
  assign LED_out = {seg, ~dp_in[digit_idx]};

endmodule

// File: tb/tb_seven_seg_scan_controller.sv
// tb/tb_seven_seg_scan_controller.sv - scoreboard bench for seven_seg_scan_controller
module tb_seven_seg_scan_controller;

  logic        clock_100Mhz = 1'b0;
  logic        reset        = 1'b1;
  logic        load         = 1'b0;
  logic [31:0] value_in     = '0;
  logic [7:0]  dp_in        = '0;
  logic        busy;
  logic [1:0]  overflow;
  logic [7:0]  anode_activate;
  logic [7:0]  LED_out;

  int n_vec    = 0;
  int n_err    = 0;
  int mon_done = 0;

  typedef struct packed {
    logic [1:0]      ovf;
    logic [7:0][6:0] seg;
  } exp_t;

  exp_t exp_q[$];

  always #5 clock_100Mhz = ~clock_100Mhz;

  seven_seg_scan_controller #(
    .NUM_FIELDS(2), .DIGITS_PER_FIELD(4), .BIN_WIDTH(16), .DIGIT_PERIOD(4)
  ) dut (
    .clock_100Mhz  (clock_100Mhz),
    .reset         (reset),
    .value_in      (value_in),
    .load          (load),
    .dp_in         (dp_in),
    .busy          (busy),
    .overflow      (overflow),
    .anode_activate(anode_activate),
    .LED_out       (LED_out)
  );

  // nibble code: 0-9 digit, D dash, E leading zero (blank when blanking is built in)
  function automatic logic [6:0] seg_exp(input logic [3:0] code);
    case (code)
      4'h0: return 7'b0000001;
      4'h1: return 7'b1001111;
      4'h2: return 7'b0010010;
      4'h3: return 7'b0000110;
      4'h4: return 7'b1001100;
      4'h5: return 7'b0100100;
      4'h6: return 7'b0100000;
      4'h7: return 7'b0001111;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0000100;
      4'hD: return 7'b1111110;
`ifdef LEADING_ZERO_BLANK_EN
      4'hE: return 7'b1111111;
`else
      4'hE: return 7'b0000001;
`endif
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic int digit_of(input logic [7:0] an);
    int r;
    logic [7:0] m;
    r = -1;
    for (int k = 0; k < 8; k++) begin
      m = 8'h80 >> k;
      m = ~m;
      if (an == m) r = k;
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // codes: digit 0 in the top nibble, digit 7 in the bottom nibble
  task automatic push_exp(input logic [1:0] ovf, input logic [31:0] codes);
    exp_t e;
    e.ovf = ovf;
    for (int k = 0; k < 8; k++) e.seg[k] = seg_exp(codes[4*(7-k) +: 4]);
    exp_q.push_back(e);
  endtask

  task automatic do_load(input logic [15:0] f0, input logic [15:0] f1);
    value_in = {f1, f0};
    load = 1'b1;
    @(negedge clock_100Mhz);
    load = 1'b0;
  endtask

  task automatic wait_mon;
    int start;
    int n;
    start = mon_done;
    n = 0;
    while (mon_done == start && n < 200) begin
      @(negedge clock_100Mhz);
      n++;
    end
    if (mon_done == start) check("commit_timeout", 32'd0, 32'd1);
  endtask

  // monitor: on each commit pop the expectation, check busy length, flags and one full scan
  initial begin : monitor
    logic       busy_prev;
    int         busy_len;
    int         d;
    exp_t       e;
    logic [6:0] cap [8];
    logic [7:0] seen;
    busy_prev = 1'b0;
    busy_len  = 0;
    forever begin
      @(negedge clock_100Mhz);
      if (busy && !busy_prev) busy_len = 0;
      if (busy) busy_len++;
      if (busy_prev && !busy && !reset) begin
        if (exp_q.size() == 0) begin
          check("unexpected_commit", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("busy_cycles", busy_len, 32'd34);
          check("overflow", 32'(overflow), 32'(e.ovf));
          seen = '0;
          for (int k = 0; k < 8; k++) cap[k] = 7'h00;
          for (int t = 0; t < 32; t++) begin
            d = digit_of(anode_activate);
            if (d >= 0) begin
              cap[d]  = LED_out[7:1];
              seen[d] = 1'b1;
            end
            if (t < 31) @(negedge clock_100Mhz);
          end
          check("all_digits_scanned", 32'(seen), 32'hFF);
          for (int k = 0; k < 8; k++)
            check($sformatf("digit%0d_seg", k), 32'(cap[k]), 32'(e.seg[k]));
        end
        mon_done++;
      end
      busy_prev = busy;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, required finish before 500000");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    logic [7:0] exp_an;
    int d;
    // reset held
    repeat (3) @(negedge clock_100Mhz);
    check("rst_anode", 32'(anode_activate), 32'h7F);
    check("rst_led", 32'(LED_out), 32'({seg_exp(4'hE), 1'b1}));
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);

    // scan timing after release: 4 cycles per digit, back to digit 0 after 32
    reset = 1'b0;
    for (int t = 0; t <= 32; t++) begin
      exp_an = 8'h80 >> ((t / 4) % 8);
      exp_an = ~exp_an;
      check($sformatf("scan_anode_t%0d", t), 32'(anode_activate), 32'(exp_an));
      @(negedge clock_100Mhz);
    end

    // basic conversion
    push_exp(2'b00, 32'h1234_EE56);
    do_load(16'd1234, 16'd56);
    wait_mon;

    // decimal point on digit 3 only
    dp_in = 8'b0000_1000;
    for (int t = 0; t < 32; t++) begin
      check("dp_led0", 32'(LED_out[0]), (anode_activate == 8'b1110_1111) ? 32'd0 : 32'd1);
      @(negedge clock_100Mhz);
    end
    dp_in = '0;

    // second load 10 cycles into a conversion is dropped
    push_exp(2'b00, 32'h4321_EEE7);
    do_load(16'd4321, 16'd7);
    repeat (9) @(negedge clock_100Mhz);
    check("busy_mid_conv", 32'(busy), 32'd1);
    do_load(16'd1111, 16'd1111);
    wait_mon;

    // overflow on field 0, then the 9999 boundary clears it, then both fields overflow
    push_exp(2'b01, 32'hDDDD_EEE0);
    do_load(16'd10000, 16'd0);
    wait_mon;
    push_exp(2'b00, 32'h9999_EEE0);
    do_load(16'd9999, 16'd0);
    wait_mon;
    push_exp(2'b11, 32'hDDDD_DDDD);
    do_load(16'd20000, 16'd60000);
    wait_mon;

    // reset at cycle 20 of a conversion aborts it
    do_load(16'd1234, 16'd56);
    repeat (19) @(negedge clock_100Mhz);
    check("busy_before_abort", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_overflow", 32'(overflow), 32'd0);
    check("abort_anode", 32'(anode_activate), 32'h7F);
    check("abort_led", 32'(LED_out[7:1]), 32'(seg_exp(4'hE)));
    repeat (2) @(negedge clock_100Mhz);
    reset = 1'b0;
    for (int t = 0; t < 40; t++) begin
      d = digit_of(anode_activate);
      check("post_abort_busy", 32'(busy), 32'd0);
      if (d >= 0)
        check($sformatf("post_abort_digit%0d", d), 32'(LED_out[7:1]),
              32'(seg_exp((d % 4 == 3) ? 4'h0 : 4'hE)));
      @(negedge clock_100Mhz);
    end
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
